vga_fb_scheduler: RTL and testbench

Shares one single-port framebuffer RAM between two users. The VGA display path reads pixels, driven by the 640x480 driver's pos_x/pos_y outputs. The camera/capture path writes pixels through a valid/ready interface.
The framebuffer is FB_W x FB_H and is upscaled by 2^SCALE_LOG2 in both axes. The display therefore needs one read every 2^SCALE_LOG2 clocks, and all other RAM slots go to buffered writes.
The block sits between the VGA driver (its pixel_o feeds the driver's pixelIn), the capture block and the framebuffer RAM.

---
 rtl/fb_pkg.sv | 37 +++
 rtl/fb_wr_fifo.sv | 77 +++++++
 rtl/vga_fb_scheduler.sv | 140 ++++++++++++++
 tb/tb_vga_fb_scheduler.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared constants and types for the VGA framebuffer scheduler.
// The framebuffer is upscaled by 2^SCALE_LOG2 onto the 640x480 screen.
package fb_pkg;

    localparam int DW         = 12;
    localparam int FB_W       = 160;
    localparam int FB_H       = 120;
    localparam int SCALE_LOG2 = 2;
    localparam int AW         = 15;
    localparam int SCREEN_X   = 640;
    localparam int SCREEN_Y   = 480;
    localparam int FB_SIZE    = FB_W * FB_H;
    localparam int PW         = 11;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wrEntry_t;

    typedef enum logic [1:0] {
        ACC_IDLE  = 2'd0,
        ACC_READ  = 2'd1,
        ACC_WRITE = 2'd2,
        ACC_DROP  = 2'd3
    } access_t;

    // Row stride of 160 is built as (row*128 + row*32) to avoid a multiplier.
    function automatic logic [AW-1:0] dispAddr(input logic [PW-1:0] posX,
                                               input logic [PW-1:0] posY);
        logic [AW-1:0] row;
        logic [AW-1:0] col;
        row = AW'(posY >> SCALE_LOG2);
        col = AW'(posX >> SCALE_LOG2);
        return (row << 7) + (row << 5) + col;
    endfunction

endpackage

// File: rtl/fb_wr_fifo.sv
// Synchronous write FIFO with registered full/empty flags and occupancy.
// Pushes while full and pops while empty are ignored.
module fb_wr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 27
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTRW = $clog2(DEPTH);
    localparam int LW   = PTRW + 1;

    logic [WIDTH-1:0] storage [DEPTH];
    logic [PTRW-1:0]  wrPtr;
    logic [PTRW-1:0]  rdPtr;
    logic [LW-1:0]    levelR;
    logic [LW-1:0]    nextLevel;
    logic             fullR;
    logic             emptyR;
    logic             doPush;
    logic             doPop;

    assign doPush = push && !fullR;
    assign doPop  = pop && !emptyR;

    // Occupancy after this cycle's push/pop.
    always_comb begin
        nextLevel = levelR;
        case ({doPush, doPop})
            2'b10:   nextLevel = levelR + LW'(1);
            2'b01:   nextLevel = levelR - LW'(1);
            default: nextLevel = levelR;
        endcase
    end

    // Pointers, level and flags; flags are registered from the next level.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr  <= '0;
            rdPtr  <= '0;
            levelR <= '0;
            fullR  <= 1'b0;
            emptyR <= 1'b1;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + PTRW'(1);
            end
            if (doPop) begin
                rdPtr <= rdPtr + PTRW'(1);
            end
            levelR <= nextLevel;
            fullR  <= (nextLevel == LW'(DEPTH));
            emptyR <= (nextLevel == LW'(0));
        end
    end

    // Entry storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (doPush) begin
            storage[wrPtr] <= wdata;
        end
    end

    assign rdata = storage[rdPtr];
    assign full  = fullR;
    assign empty = emptyR;
    assign level = levelR;

endmodule

// File: rtl/vga_fb_scheduler.sv
// Time-shares a single-port framebuffer RAM between the VGA display reads
// and buffered capture writes; display reads always win their slot.
module vga_fb_scheduler
    import fb_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [PW-1:0]                pos_x,
    input  logic [PW-1:0]                pos_y,
    output logic [DW-1:0]                pixel_o,
    input  logic                         wr_valid,
    output logic                         wr_ready,
    input  logic [AW-1:0]                wr_addr,
    input  logic [DW-1:0]                wr_data,
    output logic                         mem_en,
    output logic                         mem_we,
    output logic [AW-1:0]                mem_addr,
    output logic [DW-1:0]                mem_wdata,
    input  logic [DW-1:0]                mem_rdata,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);

    logic                  vis;
    logic                  slot;
    logic [AW-1:0]         slotAddr;
    logic                  fifoFull;
    logic                  fifoEmpty;
    logic                  fifoPush;
    logic                  fifoPop;
    wrEntry_t              pushEntry;
    wrEntry_t              headEntry;
    access_t               acc;
    logic [AW-1:0]         lastAddrR;
    logic [DW-1:0]         lastDataR;
    logic                  slotQ;
    logic                  visQ;
    logic [DW-1:0]         pixelR;

    assign vis      = (pos_x < PW'(SCREEN_X)) && (pos_y < PW'(SCREEN_Y));
    assign slot     = vis && (pos_x[SCALE_LOG2-1:0] == {SCALE_LOG2{1'b0}});
    assign slotAddr = dispAddr(pos_x, pos_y);

    // Ready comes only from the registered full flag, so a same-cycle pop
    // never opens the FIFO early.
    assign wr_ready       = !rst && !fifoFull;
    assign fifoPush       = wr_valid && wr_ready;
    assign pushEntry.addr = wr_addr;
    assign pushEntry.data = wr_data;

    fb_wr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(wrEntry_t))
    ) uFifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifoPush),
        .pop   (fifoPop),
        .wdata (pushEntry),
        .rdata (headEntry),
        .full  (fifoFull),
        .empty (fifoEmpty),
        .level (fifo_level)
    );

    // Slot arbitration: display read first, otherwise drain one FIFO entry.
    always_comb begin
        acc     = ACC_IDLE;
        fifoPop = 1'b0;
        if (rst) begin
            acc = ACC_IDLE;
        end else if (slot) begin
            acc = ACC_READ;
        end else if (!fifoEmpty) begin
            fifoPop = 1'b1;
            if (headEntry.addr < AW'(FB_SIZE)) begin
                acc = ACC_WRITE;
            end else begin
                acc = ACC_DROP;
            end
        end else begin
            acc = ACC_IDLE;
        end
    end

    // RAM port mux; address and write data hold when no access is issued.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = lastAddrR;
        mem_wdata = lastDataR;
        case (acc)
            ACC_READ: begin
                mem_en   = 1'b1;
                mem_addr = slotAddr;
            end
            ACC_WRITE: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = headEntry.addr;
                mem_wdata = headEntry.data;
            end
            default: begin
                mem_en = 1'b0;
            end
        endcase
    end

    // Remember the last driven address/data for the hold behaviour.
    always_ff @(posedge clk) begin
        if (rst) begin
            lastAddrR <= '0;
            lastDataR <= '0;
        end else if (mem_en) begin
            lastAddrR <= mem_addr;
            lastDataR <= mem_wdata;
        end
    end

    // Two-stage display pipeline: slot/visible tag, then the held pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            slotQ  <= 1'b0;
            visQ   <= 1'b0;
            pixelR <= '0;
        end else begin
            slotQ <= slot;
            visQ  <= vis;
            if (slotQ) begin
                pixelR <= mem_rdata;
            end else if (!visQ) begin
                pixelR <= '0;
            end
        end
    end

    assign pixel_o = pixelR;

endmodule

// File: tb/tb_vga_fb_scheduler.sv
// Directed bench for vga_fb_scheduler with a RAM model, a write scoreboard
// and a per-cycle display/pixel model.
module tb_vga_fb_scheduler;

    localparam int NPIX = 160 * 120;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] pos_x;
    logic [10:0] pos_y;
    logic [11:0] pixel_o;
    logic        wr_valid;
    logic        wr_ready;
    logic [14:0] wr_addr;
    logic [11:0] wr_data;
    logic        mem_en;
    logic        mem_we;
    logic [14:0] mem_addr;
    logic [11:0] mem_wdata;
    logic [11:0] mem_rdata = 12'h000;
    logic [2:0]  fifo_level;

    typedef struct {
        logic [14:0] a;
        logic [11:0] d;
    } wrEnt_t;

    wrEnt_t      wq[$];
    logic [11:0] pixQ[$];
    logic [11:0] ram [NPIX];
    logic        ramReady = 1'b0;
    int          checks = 0;
    int          errors = 0;

    vga_fb_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .pixel_o    (pixel_o),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .fifo_level (fifo_level)
    );

    always #20 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Single-port RAM model with one-cycle read latency.
    always @(posedge clk) begin
        if (!ramReady) begin
            for (int i = 0; i < NPIX; i++) begin
                ram[i] <= 12'(i * 7 + 3);
            end
            ram[323] <= 12'hABC;
            ramReady <= 1'b1;
        end else if (mem_en && mem_addr < 15'(NPIX)) begin
            if (mem_we) begin
                ram[mem_addr] <= mem_wdata;
            end else begin
                mem_rdata <= ram[mem_addr];
            end
        end
    end

    // Per-cycle monitor: display slots, ordered writes, address hold, pixels.
    always @(negedge clk) begin : monitor
        logic        v;
        logic        s;
        logic [14:0] ma;
        logic [11:0] ep;
        logic [11:0] np;
        logic [11:0] lastPix;
        logic [14:0] lastAddr;
        wrEnt_t      e;
        if (rst) begin
            chk("rstMemEn", 32'(mem_en), 32'd0);
            chk("rstWrReady", 32'(wr_ready), 32'd0);
            wq.delete();
            pixQ.delete();
            pixQ.push_back(12'h000);
            pixQ.push_back(12'h000);
            lastPix  = 12'h000;
            lastAddr = 15'd0;
        end else begin
            v  = (int'(pos_x) < 640) && (int'(pos_y) < 480);
            s  = v && (int'(pos_x) % 4 == 0);
            ma = 15'((int'(pos_y) / 4) * 160 + int'(pos_x) / 4);
            ep = pixQ.pop_front();
            chk("pixel", 32'(pixel_o), 32'(ep));
            np = !v ? 12'h000 : (s ? ram[ma] : lastPix);
            pixQ.push_back(np);
            lastPix = np;
            if (s) begin
                chk("slotEn", 32'(mem_en), 32'd1);
                chk("slotWe", 32'(mem_we), 32'd0);
                chk("slotAddr", 32'(mem_addr), 32'(ma));
                lastAddr = ma;
            end else if (mem_en) begin
                chk("nonSlotIsWrite", 32'(mem_we), 32'd1);
                chk("writeQueued", 32'(wq.size() > 0), 32'd1);
                if (mem_we && wq.size() > 0) begin
                    e = wq.pop_front();
                    chk("wrAddr", 32'(mem_addr), 32'(e.a));
                    chk("wrData", 32'(mem_wdata), 32'(e.d));
                    lastAddr = e.a;
                end
            end else begin
                chk("addrHold", 32'(mem_addr), 32'(lastAddr));
            end
            if (wr_valid && wr_ready && wr_addr < 15'(NPIX)) begin
                wq.push_back('{a: wr_addr, d: wr_data});
            end
        end
    end

    initial begin : stim
        logic        found;
        logic        acc;
        logic [14:0] ga;
        logic [11:0] gd;
        int          idx;

        rst      = 1'b1;
        pos_x    = 11'd700;
        pos_y    = 11'd0;
        wr_valid = 1'b1;
        wr_addr  = 15'd7;
        wr_data  = 12'h111;

        // Reset held with a pending write request.
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            chk("rstReady", 32'(wr_ready), 32'd0);
            chk("rstEn", 32'(mem_en), 32'd0);
            chk("rstPixel", 32'(pixel_o), 32'd0);
            chk("rstLevel", 32'(fifo_level), 32'd0);
        end
        @(posedge clk); #1;
        rst      = 1'b0;
        wr_valid = 1'b0;
        @(negedge clk);
        chk("postRstLevel", 32'(fifo_level), 32'd0);
        chk("postRstReady", 32'(wr_ready), 32'd1);

        // Display read at (12,8) and the held pixel.
        pos_y = 11'd8;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            pos_x = 11'(12 + i);
            @(negedge clk);
            if (i == 0) begin
                chk("dispEn", 32'(mem_en), 32'd1);
                chk("dispWe", 32'(mem_we), 32'd0);
                chk("dispAddr", 32'(mem_addr), 32'd323);
            end
            if (i >= 2 && i <= 5) begin
                chk("dispPixel", 32'(pixel_o), 32'hABC);
            end
        end

        // Write issued during horizontal blanking.
        @(posedge clk); #1;
        pos_x    = 11'd700;
        pos_y    = 11'd10;
        wr_valid = 1'b1;
        wr_addr  = 15'd100;
        wr_data  = 12'h123;
        @(posedge clk); #1;
        wr_valid = 1'b0;
        found    = 1'b0;
        ga       = 15'd0;
        gd       = 12'h000;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            if (!found && mem_en && mem_we) begin
                found = 1'b1;
                ga    = mem_addr;
                gd    = mem_wdata;
            end
            @(posedge clk); #1;
        end
        chk("blankWriteSeen", 32'(found), 32'd1);
        chk("blankWriteAddr", 32'(ga), 32'd100);
        chk("blankWriteData", 32'(gd), 32'h123);
        @(negedge clk);
        chk("blankPixel", 32'(pixel_o), 32'd0);

        // Entry waiting when a display slot arrives.
        @(posedge clk); #1;
        pos_y    = 11'd0;
        pos_x    = 11'd15;
        wr_valid = 1'b1;
        wr_addr  = 15'd200;
        wr_data  = 12'h456;
        @(posedge clk); #1;
        pos_x    = 11'd16;
        wr_valid = 1'b0;
        @(negedge clk);
        chk("collEn", 32'(mem_en), 32'd1);
        chk("collWe", 32'(mem_we), 32'd0);
        chk("collAddr", 32'(mem_addr), 32'd4);
        chk("collLevel", 32'(fifo_level), 32'd1);
        @(posedge clk); #1;
        pos_x = 11'd17;
        @(negedge clk);
        chk("collWrWe", 32'(mem_we), 32'd1);
        chk("collWrAddr", 32'(mem_addr), 32'd200);
        chk("collWrData", 32'(mem_wdata), 32'h456);

        // Backpressure: fill while parked on a slot, then scan and drain.
        @(posedge clk); #1;
        pos_x = 11'd0;
        pos_y = 11'd4;
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1'b1;
            wr_addr  = 15'(1000 + i);
            wr_data  = 12'(12'h700 + i);
            @(posedge clk); #1;
        end
        wr_addr = 15'd1004;
        wr_data = 12'h704;
        @(negedge clk);
        chk("bpReady", 32'(wr_ready), 32'd0);
        chk("bpLevel", 32'(fifo_level), 32'd4);
        acc = 1'b0;
        idx = 4;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (acc) idx++;
            pos_x    = 11'(c);
            wr_valid = (idx < 6);
            wr_addr  = 15'(1000 + idx);
            wr_data  = 12'(12'h700 + idx);
            @(negedge clk);
            acc = wr_valid && wr_ready;
        end
        @(posedge clk); #1;
        if (acc) idx++;
        wr_valid = 1'b0;
        chk("bpAccepted", 32'(idx), 32'd6);
        chk("bpDrained", 32'(wq.size()), 32'd0);

        // Out-of-range write is dropped; the next one still goes out.
        pos_x    = 11'd700;
        wr_valid = 1'b1;
        wr_addr  = 15'd19200;
        wr_data  = 12'hFFF;
        @(posedge clk); #1;
        wr_addr = 15'd5;
        wr_data = 12'h0A5;
        @(negedge clk);
        chk("oorNoAccess", 32'(mem_en), 32'd0);
        chk("oorLevel", 32'(fifo_level), 32'd1);
        @(posedge clk); #1;
        wr_valid = 1'b0;
        @(negedge clk);
        chk("oorNextWe", 32'(mem_we), 32'd1);
        chk("oorNextAddr", 32'(mem_addr), 32'd5);
        chk("oorNextData", 32'(mem_wdata), 32'h0A5);

        // Reset with entries queued discards them.
        @(posedge clk); #1;
        pos_x    = 11'd0;
        pos_y    = 11'd0;
        wr_valid = 1'b1;
        wr_addr  = 15'd300;
        wr_data  = 12'h001;
        @(posedge clk); #1;
        wr_addr = 15'd301;
        @(posedge clk); #1;
        wr_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        chk("midRstLevelBefore", 32'(fifo_level), 32'd2);
        chk("midRstReady", 32'(wr_ready), 32'd0);
        @(posedge clk); #1;
        rst   = 1'b0;
        pos_x = 11'd700;
        @(negedge clk);
        chk("midRstLevelAfter", 32'(fifo_level), 32'd0);
        repeat (4) @(negedge clk);
        chk("finalQueueEmpty", 32'(wq.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
